normalize_round_pack_float64: RTL

NORMALIZE_ROUND_PACK_FLOAT64 -- requirements
Module: normalize_round_pack_float64

---
 rtl/normalize_round_pack_float64_if.sv | 43 ++++
 rtl/normalize_round_pack_float64.sv | 138 +++++++++++++
 2 files changed

// File: rtl/normalize_round_pack_float64_if.sv
// rtl/normalize_round_pack_float64_if.sv - start/done handshake, operands and packed result of the float64 packer
// ap_flags exists only when NORMALIZE_ROUND_PACK_FLOAT64_FLAGS_EN is defined.
interface normalize_round_pack_float64_if;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic        zSign;
    logic [15:0] zExp;
    logic [63:0] zSig;
    logic [63:0] ap_return;
`ifdef NORMALIZE_ROUND_PACK_FLOAT64_FLAGS_EN
    logic [2:0]  ap_flags;
`endif

    modport master (
        output ap_start,
        output zSign,
        output zExp,
        output zSig,
        input  ap_done,
        input  ap_idle,
        input  ap_ready,
`ifdef NORMALIZE_ROUND_PACK_FLOAT64_FLAGS_EN
        input  ap_flags,
`endif
        input  ap_return
    );

    modport slave (
        input  ap_start,
        input  zSign,
        input  zExp,
        input  zSig,
        output ap_done,
        output ap_idle,
        output ap_ready,
`ifdef NORMALIZE_ROUND_PACK_FLOAT64_FLAGS_EN
        output ap_flags,
`endif
        output ap_return
    );
endinterface

// File: rtl/normalize_round_pack_float64.sv
// rtl/normalize_round_pack_float64.sv - normalize, round-to-nearest-even and pack an IEEE-754 double
// Optional {overflow, underflow, inexact} flags under NORMALIZE_ROUND_PACK_FLOAT64_FLAGS_EN.
module normalize_round_pack_float64 (
    input  logic ap_clk,
    input  logic ap_rst_n,
    normalize_round_pack_float64_if.slave bus
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, PACK} state_t;

    state_t      state;
    logic        sign_q;
    logic [15:0] exp_q;
    logic [63:0] sig_q;
    logic [63:0] ret_q;
    logic        done_q;

    logic        rnd_msb;
    logic        ovf;
    logic        exp_neg;
    logic [15:0] sh_amt;
    logic [63:0] lost_mask;
    logic [63:0] jam_sig;
    logic [9:0]  rb;
    logic [63:0] sum2;
    logic [63:0] mant;
    logic [15:0] exp_f;
    logic [63:0] exp_term;
    logic [63:0] packed_val;

    // Bit 63 of (sig_q + 0x200) without building the unused low sum bits.
    assign rnd_msb = sig_q[63] ^ (&sig_q[62:9]);
    assign ovf     = ($signed(exp_q) > 16'sh07FD) || ((exp_q == 16'h07FD) && rnd_msb);
    assign exp_neg = exp_q[15];
    assign sh_amt  = 16'd0 - exp_q;

    always_comb begin
        jam_sig   = sig_q;
        lost_mask = '0;
        if (exp_neg) begin
            if (sh_amt >= 16'd64) begin
                jam_sig = {63'b0, |sig_q};
            end else begin
                lost_mask = ~(64'hFFFF_FFFF_FFFF_FFFF << sh_amt[5:0]);
                jam_sig   = (sig_q >> sh_amt[5:0]) | {63'b0, |(sig_q & lost_mask)};
            end
        end
    end

    always_comb begin
        rb    = jam_sig[9:0];
        sum2  = jam_sig + 64'h200;
        mant  = sum2 >> 10;
        // Exact tie: round to even.
        if (rb == 10'h200) begin
            mant[0] = 1'b0;
        end
        exp_f = exp_neg ? 16'd0 : exp_q;
        if (mant == 64'd0) begin
            exp_f = 16'd0;
        end
        exp_term   = {48'b0, exp_f} << 52;
        packed_val = {sign_q, 63'b0} + exp_term + mant;
    end

`ifdef NORMALIZE_ROUND_PACK_FLOAT64_FLAGS_EN
    logic       tiny;
    logic [2:0] flags_q;
    logic [2:0] flags_d;

    assign tiny    = exp_neg && (($signed(exp_q) < -16'sd1) || !rnd_msb);
    assign flags_d = ovf ? 3'b101 : {1'b0, tiny && (rb != 10'd0), rb != 10'd0};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            flags_q <= 3'b000;
        end else if (state == ROUND) begin
            flags_q <= flags_d;
        end
    end

    assign bus.ap_flags = flags_q;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state  <= IDLE;
            sign_q <= 1'b0;
            exp_q  <= 16'd0;
            sig_q  <= 64'd0;
            ret_q  <= 64'd0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.ap_start) begin
                        sign_q <= bus.zSign;
                        exp_q  <= bus.zExp;
                        sig_q  <= bus.zSig;
                        state  <= NORM;
                    end
                end
                NORM: begin
                    if ((sig_q == 64'd0) || (sig_q[63:62] == 2'b01)) begin
                        state <= ROUND;
                    end else if (sig_q[63]) begin
                        sig_q <= {1'b0, sig_q[63:2], sig_q[1] | sig_q[0]};
                        exp_q <= exp_q + 16'd1;
                        state <= ROUND;
                    end else begin
                        sig_q <= {sig_q[62:0], 1'b0};
                        exp_q <= exp_q - 16'd1;
                    end
                end
                ROUND: begin
                    ret_q  <= ovf ? {sign_q, 11'h7FF, 52'b0} : packed_val;
                    done_q <= 1'b1;
                    state  <= PACK;
                end
                PACK: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.ap_done   = done_q;
    assign bus.ap_ready  = done_q;
    assign bus.ap_return = ret_q;
    assign bus.ap_idle   = (state == IDLE) && !bus.ap_start;

endmodule
